b16_dbg_host: RTL and testbench

Host-side initiator for the b16 CPU debug port. Accepts a byte command stream from a serial link (UART or similar) through a valid/ready interface and turns it into single-cycle `dr`/`dw` strobes on the CPU's `daddr`/`din`/`dout` debug bus. Owns the CPU `run` line for halt, resume and single-step. Sits between the link byte FIFO and the `cpu` instance, replacing memory-mapped self-debug when an external host is attached.

---
 rtl/b16_dbg_pkg.sv | 34 +++
 rtl/b16_dbg_host_if.sv | 24 ++
 rtl/b16_dbg_host.sv | 192 +++++++++++++++++++
 tb/tb_b16_dbg_host.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/b16_dbg_pkg.sv
// Shared definitions for the b16 host-side debug initiator: command op codes,
// default response bytes, debug register addresses and the FSM state encoding.
package b16_dbg_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_HALT  = 2'b10,
        OP_RUN   = 2'b11
    } op_e;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;

    localparam logic [2:0] DA_N      = 3'd0;
    localparam logic [2:0] DA_RSTACK = 3'd1;
    localparam logic [2:0] DA_BP     = 3'd2;
    localparam logic [2:0] DA_STATUS = 3'd3;
    localparam logic [2:0] DA_P      = 3'd4;
    localparam logic [2:0] DA_T      = 3'd5;
    localparam logic [2:0] DA_R      = 3'd6;
    localparam logic [2:0] DA_I      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG_HI,
        ST_ARG_LO,
        ST_EXEC,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_SEND1
    } state_e;

endpackage

// File: rtl/b16_dbg_host_if.sv
// Byte link between the serial front end and the debug host: a receive
// channel carrying command bytes in and a transmit channel carrying responses out.
interface b16_dbg_host_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Link side: produces command bytes, consumes response bytes.
    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    // Debug host side: consumes command bytes, produces response bytes.
    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/b16_dbg_host.sv
// Host-side initiator for the b16 debug port. Decodes a byte command stream
// into single-clock dr/dw strobes and owns the CPU run line (halt/go/step).
module b16_dbg_host
    import b16_dbg_pkg::*;
#(
    parameter int         l            = 16,
    parameter bit         RUN_AT_RESET = 1'b1,
    parameter logic [7:0] ACK          = ACK_DEFAULT,
    parameter logic [7:0] NAK          = NAK_DEFAULT
) (
    input  logic              clk,
    input  logic              nreset,
    b16_dbg_host_if.slave     link,
    output logic              run,
    output logic              dr,
    output logic              dw,
    output logic [2:0]        daddr,
    output logic [l-1:0]      din,
    input  logic [l-1:0]      dout
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [2:0]     addr_q, addr_d;
    logic           sel_q, sel_d;
    logic [l-1:0]   arg_q, arg_d;
    logic           nak_q, nak_d;
    logic           step_q, step_d;
    logic [l-1:0]   cap_q, cap_d;
    logic           run_q, run_d;
    logic           dr_q, dr_d;
    logic           dw_q, dw_d;
    logic [2:0]     daddr_q, daddr_d;
    logic [l-1:0]   din_q, din_d;
    logic           rx_ready_q, rx_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           accept;
    logic           tx_done;
    logic           enter_exec;

    assign accept  = link.rx_valid & rx_ready_q;
    assign tx_done = tx_valid_q & link.tx_ready;

    // Next-state and output decode; strobes and run changes are set up on
    // the edge entering EXEC so the CPU sees each side effect exactly once.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        arg_d      = arg_q;
        nak_d      = nak_q;
        step_d     = step_q;
        cap_d      = cap_q;
        run_d      = run_q;
        dr_d       = 1'b0;
        dw_d       = 1'b0;
        daddr_d    = daddr_q;
        din_d      = din_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        enter_exec = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = op_e'(link.rx_data[7:6]);
                    addr_d = link.rx_data[2:0];
                    sel_d  = link.rx_data[0];
                    if (op_e'(link.rx_data[7:6]) == OP_WRITE) begin
                        state_d = ST_ARG_HI;
                    end else begin
                        enter_exec = 1'b1;
                    end
                end
            end
            ST_ARG_HI: begin
                if (accept) begin
                    arg_d[15:8] = link.rx_data;
                    state_d     = ST_ARG_LO;
                end
            end
            ST_ARG_LO: begin
                if (accept) begin
                    arg_d[7:0] = link.rx_data;
                    enter_exec = 1'b1;
                end
            end
            ST_EXEC: begin
                tx_valid_d = 1'b1;
                if (dr_q) begin
                    cap_d     = dout;
                    tx_data_d = dout[15:8];
                    state_d   = ST_SEND_HI;
                end else begin
                    tx_data_d = nak_q ? NAK : ACK;
                    state_d   = ST_SEND1;
                end
                if (step_q) begin
                    run_d = 1'b0;
                end
                step_d = 1'b0;
            end
            ST_SEND_HI: begin
                if (tx_done) begin
                    tx_data_d = cap_q[7:0];
                    state_d   = ST_SEND_LO;
                end
            end
            ST_SEND_LO, ST_SEND1: begin
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_exec) begin
            state_d = ST_EXEC;
            daddr_d = addr_d;
            nak_d   = run_q && ((op_d == OP_READ) || (op_d == OP_WRITE) ||
                                ((op_d == OP_RUN) && sel_d));
            step_d  = (op_d == OP_RUN) && sel_d && !run_q;
            case (op_d)
                OP_READ:  dr_d = !run_q;
                OP_WRITE: begin
                    dw_d = !run_q;
                    din_d = arg_d;
                end
                OP_HALT:  run_d = 1'b0;
                OP_RUN:   run_d = sel_d ? !run_q : 1'b1;
                default:  run_d = run_q;
            endcase
        end

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ARG_HI) ||
                     (state_d == ST_ARG_LO);
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            addr_q     <= 3'd0;
            sel_q      <= 1'b0;
            arg_q      <= '0;
            nak_q      <= 1'b0;
            step_q     <= 1'b0;
            cap_q      <= '0;
            run_q      <= RUN_AT_RESET;
            dr_q       <= 1'b0;
            dw_q       <= 1'b0;
            daddr_q    <= 3'd0;
            din_q      <= '0;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            arg_q      <= arg_d;
            nak_q      <= nak_d;
            step_q     <= step_d;
            cap_q      <= cap_d;
            run_q      <= run_d;
            dr_q       <= dr_d;
            dw_q       <= dw_d;
            daddr_q    <= daddr_d;
            din_q      <= din_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign run           = run_q;
    assign dr            = dr_q;
    assign dw            = dw_q;
    assign daddr         = daddr_q;
    assign din           = din_q;
    assign link.rx_ready = rx_ready_q;
    assign link.tx_valid = tx_valid_q;
    assign link.tx_data  = tx_data_q;

endmodule

// File: tb/tb_b16_dbg_host.sv
// Directed bench for b16_dbg_host with a small behavioural CPU debug model
// (data stack at daddr 0, P at 4, T at 5; P advances on every run clock).
module tb_b16_dbg_host;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        run, dr, dw;
    logic [2:0]  daddr;
    logic [15:0] din, dout;

    int total = 0;
    int bad = 0;

    b16_dbg_host_if link();

    b16_dbg_host #(.l(16), .RUN_AT_RESET(1'b1)) dut (
        .clk(clk), .nreset(nreset), .link(link.slave),
        .run(run), .dr(dr), .dw(dw), .daddr(daddr), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    // CPU model state and strobe/run counters
    logic [15:0] stk [0:7];
    int          sp = 0;
    logic [15:0] p_reg = 16'h0000;
    logic [15:0] t_reg = 16'h0000;
    int          dr_cnt = 0;
    int          dw_cnt = 0;
    int          run_cnt = 0;

    // Combinational read data from the CPU model
    always_comb begin
        dout = 16'h0000;
        if (dr && !run) begin
            case (daddr)
                3'd0:    dout = (sp > 0) ? stk[sp-1] : 16'hDEAD;
                3'd4:    dout = p_reg;
                3'd5:    dout = t_reg;
                default: dout = 16'h0000;
            endcase
        end
    end

    // CPU model side effects and strobe counting
    always @(posedge clk) begin
        if (dw) begin
            dw_cnt <= dw_cnt + 1;
            case (daddr)
                3'd0: begin stk[sp] <= din; sp <= sp + 1; end
                3'd4: p_reg <= din;
                3'd5: t_reg <= din;
                default: ;
            endcase
        end
        if (dr) begin
            dr_cnt <= dr_cnt + 1;
            if (!run && daddr == 3'd0 && sp > 0) sp <= sp - 1;
        end
        if (run && nreset) begin
            run_cnt <= run_cnt + 1;
            p_reg <= p_reg + 16'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        link.rx_data  = b;
        link.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (link.rx_ready) begin
                @(posedge clk);
                got = 1;
            end
        end
        #1;
        link.rx_valid = 1'b0;
        if (!got) check("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        bit got = 0;
        logic [7:0] b = 8'h00;
        link.tx_ready = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (link.tx_valid) begin
                b = link.tx_data;
                @(posedge clk);
                got = 1;
            end
        end
        #1;
        link.tx_ready = 1'b0;
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        else      check(tag, {24'd0, b}, {24'd0, exp});
    endtask

    int dr0, dw0, run0;

    initial begin
        link.rx_data  = 8'h00;
        link.rx_valid = 1'b0;
        link.tx_ready = 1'b0;
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_run", run, 1'b1);
        check("rst_strobes", {dr, dw}, 2'b00);
        check("rst_daddr_din", {daddr, din}, 19'd0);
        check("rst_rx_ready", link.rx_ready, 1'b0);
        check("rst_tx", {link.tx_valid, link.tx_data}, 9'd0);
        nreset = 1'b1;
        @(posedge clk); #1;
        check("rx_ready_after_reset", link.rx_ready, 1'b1);

        // HALT
        dr0 = dr_cnt; dw0 = dw_cnt;
        send_byte(8'h80);
        recv_byte("halt_ack", 8'hA5);
        check("halt_run", run, 1'b0);
        check("halt_no_strobe", (dr_cnt - dr0) + (dw_cnt - dw0), 0);

        // WRITE T = 1234, then READ T
        send_byte(8'h45); send_byte(8'h12); send_byte(8'h34);
        check("wr_dw", dw, 1'b1);
        check("wr_daddr", daddr, 3'd5);
        check("wr_din", din, 16'h1234);
        @(posedge clk); #1;
        check("wr_dw_one_clock", dw, 1'b0);
        recv_byte("wr_ack", 8'hA5);
        dr0 = dr_cnt;
        send_byte(8'h05);
        check("rd_dr", {dr, daddr}, {1'b1, 3'd5});
        recv_byte("rd_t_hi", 8'h12);
        recv_byte("rd_t_lo", 8'h34);
        check("rd_one_dr", dr_cnt - dr0, 1);

        // Stack LIFO through daddr 0
        dr0 = dr_cnt; dw0 = dw_cnt;
        send_byte(8'h40); send_byte(8'h11); send_byte(8'h11); recv_byte("push1_ack", 8'hA5);
        send_byte(8'h40); send_byte(8'h22); send_byte(8'h22); recv_byte("push2_ack", 8'hA5);
        send_byte(8'h40); send_byte(8'h33); send_byte(8'h33); recv_byte("push3_ack", 8'hA5);
        send_byte(8'h00); recv_byte("pop1_hi", 8'h33); recv_byte("pop1_lo", 8'h33);
        send_byte(8'h00); recv_byte("pop2_hi", 8'h22); recv_byte("pop2_lo", 8'h22);
        send_byte(8'h00); recv_byte("pop3_hi", 8'h11); recv_byte("pop3_lo", 8'h11);
        check("stack_dw_count", dw_cnt - dw0, 3);
        check("stack_dr_count", dr_cnt - dr0, 3);

        // STEP from P = 3FFE
        send_byte(8'h44); send_byte(8'h3F); send_byte(8'hFE); recv_byte("wr_p_ack", 8'hA5);
        run0 = run_cnt;
        send_byte(8'hC1);
        check("step_run_high", run, 1'b1);
        @(posedge clk); #1;
        check("step_run_low", run, 1'b0);
        recv_byte("step_ack", 8'hA5);
        check("step_run_clocks", run_cnt - run0, 1);
        send_byte(8'h04); recv_byte("rd_p_hi", 8'h3F); recv_byte("rd_p_lo", 8'hFF);

        // GO, then rejected WRITE and STEP while running
        send_byte(8'hC0); recv_byte("go_ack", 8'hA5);
        check("go_run", run, 1'b1);
        dw0 = dw_cnt;
        send_byte(8'h45); send_byte(8'hAA); send_byte(8'hBB);
        recv_byte("wr_running_nak", 8'hEE);
        check("wr_running_no_dw", dw_cnt - dw0, 0);
        send_byte(8'hC1); recv_byte("step_running_nak", 8'hEE);
        check("step_running_halts", run, 1'b0);

        // Stalled READ response, then reset mid-stall
        dr0 = dr_cnt;
        send_byte(8'h05);
        repeat (20) @(negedge clk);
        check("stall_tx_valid", link.tx_valid, 1'b1);
        check("stall_tx_data", link.tx_data, 8'h12);
        check("stall_rx_ready", link.rx_ready, 1'b0);
        check("stall_one_dr", dr_cnt - dr0, 1);
        #2 nreset = 1'b0;
        #1;
        check("abort_run", run, 1'b1);
        check("abort_outputs", {dr, dw, daddr, din}, 21'd0);
        check("abort_link", {link.rx_ready, link.tx_valid, link.tx_data}, 10'd0);
        @(posedge clk); #1;
        check("abort_hold", {link.rx_ready, link.tx_valid, run}, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
